inst_fetch: RTL

Instruction fetch stage sitting directly downstream of the PC next-address unit. Accepts the current `pc`, issues a word read to instruction memory over a request/grant + response-valid interface with variable latency, and presents the returned instruction with its PC to decode through a valid/ready handshake. Back-pressures the PC stage via `pcStall` and discards in-flight fetches on a control-flow `flush`.

---
 rtl/inst_fetch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one word read per accepted PC over a req/gnt + rvalid
// memory port, result handed to decode with valid/ready; flush kills the fetch.
module inst_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pcStall,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memGnt,
  input  logic              memRvalid,
  input  logic [DATA_W-1:0] memRdata,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] instPc,
  output logic              instMisalign,
  output logic              instValid,
  input  logic              instReady,
  output logic [31:0]       fetchCount
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_mis_q, req_mis_d;
  logic              discard_q, discard_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_mis_q, inst_mis_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    req_mis_d     = req_mis_q;
    discard_d     = discard_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_mis_d    = inst_mis_q;
    inst_valid_d  = inst_valid_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          req_pc_d   = pc;
          req_mis_d  = |pc[1:0];
          mem_addr_d = {pc[ADDR_W-1:2], 2'b00};
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        // A flushed request is still carried to completion; its data is dropped later.
        if (flush) discard_d = 1'b1;
        if (memGnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memRvalid) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            inst_d       = memRdata;
            inst_pc_d    = req_pc_q;
            inst_mis_d   = req_mis_q;
            inst_valid_d = 1'b1;
            state_d      = S_FULL;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      S_FULL: begin
        if (flush) begin
          inst_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else if (instReady) begin
          inst_valid_d  = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_pc_q      <= '0;
      req_mis_q     <= 1'b0;
      discard_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_mis_q    <= 1'b0;
      inst_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      req_mis_q     <= req_mis_d;
      discard_q     <= discard_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_mis_q    <= inst_mis_d;
      inst_valid_q  <= inst_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pcStall      = (state_q != S_IDLE) | flush;
  assign memReq       = mem_req_q;
  assign memAddr      = mem_addr_q;
  assign inst         = inst_q;
  assign instPc       = inst_pc_q;
  assign instMisalign = inst_mis_q;
  assign instValid    = inst_valid_q;
  assign fetchCount   = fetch_count_q;

endmodule
